// File: rtl/gemm_result_drain.sv
// Result drain buffer between the GEMM MAC array and a ready/valid consumer.
// Circular FIFO with drop-on-full overflow flag and output tile framing (out_last).
module gemm_result_drain #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_DEPTH      = 16,
   parameter int C_TILE_LEN   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [C_DATA_WIDTH-1:0]   in_data,
   input  logic                      in_valid,
   output logic [C_DATA_WIDTH-1:0]   out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic [$clog2(C_DEPTH):0]  level,
   output logic                      overflow
);

   localparam int AW = $clog2(C_DEPTH);
   localparam int TW = (C_TILE_LEN > 1) ? $clog2(C_TILE_LEN) : 1;
   localparam logic [TW-1:0] TILE_MAX = TW'(C_TILE_LEN - 1);
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(C_DEPTH);

   logic [C_DATA_WIDTH-1:0] mem_q [C_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [TW-1:0] tile_cnt_q, tile_cnt_d;
   logic          overflow_q, overflow_d;

   logic full;
   logic pop;
   logic push;

   always_comb begin
      full = (level_q == LVL_FULL);
      pop  = (level_q != '0) && out_ready;
      // A full buffer still accepts a word when a pop frees a slot on the same edge.
      push = in_valid && (!full || pop);
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      tile_cnt_d = tile_cnt_q;
      overflow_d = overflow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         if (tile_cnt_q == TILE_MAX) begin
            tile_cnt_d = '0;
         end else begin
            tile_cnt_d = tile_cnt_q + TW'(1);
         end
      end

      case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase

      if (in_valid && !push) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         tile_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         tile_cnt_q <= tile_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset so it maps onto plain RAM; stale words are unreachable after reset.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      out_valid = (level_q != '0);
      out_data  = mem_q[rd_ptr_q];
      out_last  = out_valid && (tile_cnt_q == TILE_MAX);
      level     = level_q;
      overflow  = overflow_q;
   end

endmodule
